serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Bit-serial, LSB-first two-operand subtractor. Computes diff = a - b, one bit per clock, using the half/full-subtractor bit-cell: d = a^b^br, br' = (~a&b) | (~(a^b)&br).
- Counterpart to the adder datapath blocks; used where area matters more than latency.
- Operands load on a start/ready handshake. The result is presented with a one-cycle done pulse and held until the next accepted start.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous reset, active-low
- start  input  1  request; accepted when start & ready at a rising clk edge
- ready  output  1  high only in IDLE
- a  input  WIDTH  minuend; sampled on the accept edge only
- b  input  WIDTH  subtrahend; sampled on the accept edge only
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; result valid
- diff  output  WIDTH  a - b modulo 2^WIDTH; registered and held
- borrow_out  output  1  final borrow (1 when a < b unsigned); registered and held

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values (rst_n low, any time, including mid-operation):
  - state = IDLE, bit counter = 0, shift registers = 0, internal borrow = 0
  - diff = 0, borrow_out = 0, done = 0, busy = 0, ready = 1
  - An operation in progress is discarded; no done pulse follows reset release.
- State machine (states IDLE, RUN, DONE):
  - IDLE: ready = 1.
    - On start & ready: load a_sh <= a, b_sh <= b, res_sh <= 0, br <= 0, cnt <= 0; go to RUN.
  - RUN: each edge, take bit 0 of a_sh and b_sh.
    - d = a0^b0^br; br <= (~a0&b0) | (~(a0^b0)&br).
    - res_sh <= {d, res_sh[WIDTH-1:1]}; a_sh and b_sh shift right by one; cnt <= cnt + 1.
    - On the edge where cnt == WIDTH-1: diff <= {d, res_sh[WIDTH-1:1]}, borrow_out <= new br; go to DONE.
  - DONE: done = 1 for exactly this cycle, busy = 1, ready = 0; unconditionally go to IDLE on the next edge.
- Latency and throughput:
  - Accept at edge k. diff, borrow_out and done are visible after edge k+WIDTH.
  - ready returns after edge k+WIDTH+1.
  - Minimum start-to-start spacing is WIDTH+2 cycles.
- Handshake rules:
  - start while ready = 0 is ignored; no queuing, no effect on the operation in progress.
  - start may stay high continuously; each return to IDLE accepts a new operation.
  - a and b may change freely after the accept edge.
- Output hold: diff and borrow_out change only on the edge entering DONE (or on reset). The old result stays visible throughout the next RUN.
- Counter: width clog2(WIDTH)+1, so WIDTH = 1 works (a single RUN cycle); no wrap-around inside an operation.
- Arithmetic: unsigned modulo 2^WIDTH. Equal operands give diff = 0, borrow_out = 0.

Optional Feature:
- Macro SERIAL_SUB_OVF_EN.
- Defined: adds output port ovf (1 bit, reset 0).
  - Updated with diff on the edge entering DONE; held otherwise.
  - ovf = signed two's-complement overflow = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]).
  - Computed from captured MSBs: a_sh[0] and b_sh[0] in the final RUN cycle, plus d.
- Undefined: no ovf port and no associated logic; all other behaviour identical.

Test Plan:
- WIDTH=8, reset, then start with a=0x5A, b=0x23 → done exactly 8 cycles after accept; diff=0x37, borrow_out=0; ready high one cycle later.
- a=0x10, b=0x20 → diff=0xF0, borrow_out=1. a=0x00, b=0x01 → diff=0xFF, borrow_out=1. a=0xFF, b=0xFF → diff=0x00, borrow_out=0.
- Accept a=0x05, b=0x03; pulse start with a=0x99, b=0x11 during RUN → ignored; result diff=0x02. done pulses once and lasts one cycle; diff holds 0x02 through the following idle cycles.
- start held high continuously with changing operands → operations accepted every 10 cycles (WIDTH+2); each result matches the operands sampled at its accept edge.
- Assert rst_n low at RUN cycle 4, asynchronously (not clock-aligned) → all outputs reset immediately; ready=1 after release; no spurious done. A fresh 0x5A-0x23 afterwards gives 0x37.
- With SERIAL_SUB_OVF_EN: 0x80-0x01 → diff=0x7F, ovf=1. 0x7F-0xFF → diff=0x80, ovf=1. 0x05-0x03 → ovf=0. WIDTH=1: 0-1 → diff=1, borrow_out=1, done one cycle after accept.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor: start/ready handshake plus held result.
// SERIAL_SUB_OVF_EN adds the signed-overflow flag ovf.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (
        output start, a, b,
        input  ready, busy, done, diff, borrow_out, ovf
    );

    modport slave (
        input  start, a, b,
        output ready, busy, done, diff, borrow_out, ovf
    );
`else
    modport master (
        output start, a, b,
        input  ready, busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b,
        output ready, busy, done, diff, borrow_out
    );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b, one bit per clock, result held until next run.
// Optional SERIAL_SUB_OVF_EN adds a registered signed-overflow flag (bus.ovf).
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic             a0, b0, d_bit, br_new;
    logic [WIDTH-1:0] res_shift;

    always_comb begin
        a0     = a_sh_q[0];
        b0     = b_sh_q[0];
        d_bit  = a0 ^ b0 ^ br_q;
        br_new = (~a0 & b0) | (~(a0 ^ b0) & br_q);
        // Shift then insert at MSB; avoids a zero-width slice when WIDTH == 1.
        res_shift            = res_sh_q >> 1;
        res_shift[WIDTH-1]   = d_bit;

        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        br_d     = br_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d    = ovf_q;
`endif

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    a_sh_d   = bus.a;
                    b_sh_d   = bus.b;
                    res_sh_d = '0;
                    br_d     = 1'b0;
                    cnt_d    = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                br_d     = br_new;
                res_sh_d = res_shift;
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    diff_d   = res_shift;
                    borrow_d = br_new;
`ifdef SERIAL_SUB_OVF_EN
                    // Final cycle sees the operand MSBs and the result MSB.
                    ovf_d    = (a0 != b0) & (d_bit != a0);
`endif
                    state_d  = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            br_q     <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            br_q     <= br_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.ready      = (state_q == StIdle);
    assign bus.busy       = (state_q == StRun) || (state_q == StDone);
    assign bus.done       = (state_q == StDone);
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf        = ovf_q;
`endif

endmodule
